// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and decoded-command output bundle of the UART command parser.
// The master side feeds received bytes; the slave side (the parser) returns commands and status.
interface uart_cmd_parser_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_arg;
  logic        cmd_valid;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  modport master (
    output rx_byte, rx_valid,
    input  cmd_code, cmd_arg, cmd_valid, frame_err, err_count, busy
  );

  modport slave (
    input  rx_byte, rx_valid,
    output cmd_code, cmd_arg, cmd_valid, frame_err, err_count, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses 5-byte frames (SOF, CMD, ARG_H, ARG_L, CHK) from a UART byte stream,
// publishing accepted commands and flagging rejected or timed-out frames.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
  input logic              clk,
  input logic              rst_n,
  uart_cmd_parser_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_SOF,
    GET_CMD,
    GET_ARGH,
    GET_ARGL,
    GET_CHK
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       cmd_sh;
  logic [7:0]       argh_sh;
  logic [7:0]       argl_sh;
  logic             timeout;
  logic             accept;
  logic             reject;

  // A byte arriving on the timeout cycle takes priority over the timeout.
  assign timeout = (state != WAIT_SOF) && !bus.rx_valid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_SOF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = WAIT_SOF;
    end else if (bus.rx_valid) begin
      case (state)
        WAIT_SOF: if (bus.rx_byte == SOF_BYTE) state_next = GET_CMD;
        GET_CMD:  state_next = (bus.rx_byte == 8'h00) ? WAIT_SOF : GET_ARGH;
        GET_ARGH: state_next = GET_ARGL;
        GET_ARGL: state_next = GET_CHK;
        GET_CHK:  state_next = WAIT_SOF;
        default:  state_next = WAIT_SOF;
      endcase
    end
  end

  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    if (timeout) begin
      reject = 1'b1;
    end else if (bus.rx_valid) begin
      case (state)
        GET_CMD: reject = (bus.rx_byte == 8'h00);
        GET_CHK: begin
          accept = (bus.rx_byte == (cmd_sh ^ argh_sh ^ argl_sh));
          reject = (bus.rx_byte != (cmd_sh ^ argh_sh ^ argl_sh));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (bus.rx_valid || (state == WAIT_SOF)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_sh  <= '0;
      argh_sh <= '0;
      argl_sh <= '0;
    end else if (bus.rx_valid) begin
      case (state)
        GET_CMD:  if (bus.rx_byte != 8'h00) cmd_sh <= bus.rx_byte;
        GET_ARGH: argh_sh <= bus.rx_byte;
        GET_ARGL: argl_sh <= bus.rx_byte;
        default: ;
      endcase
    end
  end

  // Published command only moves on acceptance, so rejected frames leave it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cmd_code  <= '0;
      bus.cmd_arg   <= '0;
      bus.cmd_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_count <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.cmd_valid <= accept;
      bus.frame_err <= reject;
      bus.busy      <= (state_next != WAIT_SOF);
      if (accept) begin
        bus.cmd_code <= cmd_sh;
        bus.cmd_arg  <= {argh_sh, argl_sh};
      end
      if (reject && (bus.err_count != 8'hFF)) begin
        bus.err_count <= bus.err_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a table of frames with hand-computed results,
// plus sequences for timeout, byte-on-timeout, mid-frame reset and error saturation.
module tb_uart_cmd_parser;
  localparam int unsigned TMO = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(TMO),
    .SOF_BYTE      (8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:7][7:0] data;
    int              len;
    logic            exp_valid;
    logic            exp_err;
    logic [7:0]      exp_code;
    logic [15:0]     exp_arg;
    logic [7:0]      exp_cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the next negedge, where the byte's registered result is visible.
  task automatic apply_stimulus(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_status(input string name, input logic v, input logic e, input logic [7:0] code,
                              input logic [15:0] arg, input logic [7:0] cnt, input logic bsy);
    check_output({name, ".cmd_valid"}, 32'(bus.cmd_valid), 32'(v));
    check_output({name, ".frame_err"}, 32'(bus.frame_err), 32'(e));
    check_output({name, ".cmd_code"},  32'(bus.cmd_code),  32'(code));
    check_output({name, ".cmd_arg"},   32'(bus.cmd_arg),   32'(arg));
    check_output({name, ".err_count"}, 32'(bus.err_count), 32'(cnt));
    check_output({name, ".busy"},      32'(bus.busy),      32'(bsy));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp_cnt;

    vecs[0] = '{data: {8'hA5, 8'h01, 8'h12, 8'h34, 8'h27, 24'h0}, len: 5,
                exp_valid: 1'b1, exp_err: 1'b0, exp_code: 8'h01, exp_arg: 16'h1234, exp_cnt: 8'd0};
    vecs[1] = '{data: {8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 24'h0}, len: 5,
                exp_valid: 1'b0, exp_err: 1'b1, exp_code: 8'h01, exp_arg: 16'h1234, exp_cnt: 8'd1};
    vecs[2] = '{data: {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h05, 8'hAB, 8'hCD, 8'h63}, len: 8,
                exp_valid: 1'b1, exp_err: 1'b0, exp_code: 8'h05, exp_arg: 16'hABCD, exp_cnt: 8'd1};
    vecs[3] = '{data: {8'hA5, 8'h00, 48'h0}, len: 2,
                exp_valid: 1'b0, exp_err: 1'b1, exp_code: 8'h05, exp_arg: 16'hABCD, exp_cnt: 8'd2};
    vecs[4] = '{data: {8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 24'h0}, len: 5,
                exp_valid: 1'b1, exp_err: 1'b0, exp_code: 8'hA5, exp_arg: 16'hA5A5, exp_cnt: 8'd2};
    vecs[5] = '{data: {8'hA5, 8'h10, 8'h20, 8'h30, 8'h00, 24'h0}, len: 5,
                exp_valid: 1'b1, exp_err: 1'b0, exp_code: 8'h10, exp_arg: 16'h2030, exp_cnt: 8'd2};
    vecs[6] = '{data: {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 24'h0}, len: 5,
                exp_valid: 1'b1, exp_err: 1'b0, exp_code: 8'hFF, exp_arg: 16'hFFFF, exp_cnt: 8'd2};
    vecs[7] = '{data: {8'hA5, 8'h7E, 8'h00, 8'h01, 8'h7E, 24'h0}, len: 5,
                exp_valid: 1'b0, exp_err: 1'b1, exp_code: 8'hFF, exp_arg: 16'hFFFF, exp_cnt: 8'd3};

    bus.rx_byte  = 8'h00;
    bus.rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_status("reset", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < vecs[i].len; j++) begin
        apply_stimulus(vecs[i].data[j]);
        if (j < vecs[i].len - 1) begin
          check_output($sformatf("vec%0d.byte%0d.cmd_valid", i, j), 32'(bus.cmd_valid), 32'd0);
          check_output($sformatf("vec%0d.byte%0d.frame_err", i, j), 32'(bus.frame_err), 32'd0);
        end
      end
      check_status($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_err,
                   vecs[i].exp_code, vecs[i].exp_arg, vecs[i].exp_cnt, 1'b0);
      @(negedge clk);
      check_output($sformatf("vec%0d.pulse_end", i), 32'({bus.cmd_valid, bus.frame_err}), 32'd0);
    end

    // Silence after A5,03: frame_err must appear exactly after TMO idle cycles.
    apply_stimulus(8'hA5);
    apply_stimulus(8'h03);
    check_output("tmo.busy_mid", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= int'(TMO); k++) begin
      @(negedge clk);
      check_output($sformatf("tmo.err_k%0d", k), 32'(bus.frame_err), (k == int'(TMO)) ? 32'd1 : 32'd0);
    end
    check_status("tmo.after", 1'b0, 1'b1, 8'hFF, 16'hFFFF, 8'd4, 1'b0);
    @(negedge clk);
    check_output("tmo.pulse_end", 32'(bus.frame_err), 32'd0);
    apply_stimulus(8'hA5);
    apply_stimulus(8'h01);
    apply_stimulus(8'h12);
    apply_stimulus(8'h34);
    apply_stimulus(8'h27);
    check_status("tmo.next_frame", 1'b1, 1'b0, 8'h01, 16'h1234, 8'd4, 1'b0);
    @(negedge clk);

    // Byte landing on the timeout cycle wins over the timeout.
    apply_stimulus(8'hA5);
    apply_stimulus(8'h03);
    for (int k = 1; k < int'(TMO); k++) begin
      check_output($sformatf("race.idle_k%0d", k), 32'(bus.frame_err), 32'd0);
      @(negedge clk);
    end
    apply_stimulus(8'h12);
    check_output("race.no_err", 32'(bus.frame_err), 32'd0);
    check_output("race.busy", 32'(bus.busy), 32'd1);
    apply_stimulus(8'h34);
    apply_stimulus(8'h25);
    check_status("race.accept", 1'b1, 1'b0, 8'h03, 16'h1234, 8'd4, 1'b0);
    @(negedge clk);

    // Reset mid-frame: outputs clear asynchronously and no pulse follows.
    apply_stimulus(8'hA5);
    apply_stimulus(8'h01);
    apply_stimulus(8'h12);
    check_output("rst.busy_before", 32'(bus.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_status("rst.async", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_status($sformatf("rst.after%0d", k), 1'b0, 1'b0, 8'h00, 16'h0000, 8'd0, 1'b0);
    end
    apply_stimulus(8'h34);
    apply_stimulus(8'h27);
    check_status("rst.wait_sof", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd0, 1'b0);
    apply_stimulus(8'hA5);
    apply_stimulus(8'h01);
    apply_stimulus(8'h12);
    apply_stimulus(8'h34);
    apply_stimulus(8'h27);
    check_status("rst.fresh_frame", 1'b1, 1'b0, 8'h01, 16'h1234, 8'd0, 1'b0);
    @(negedge clk);

    // 260 bad-checksum frames: err_count saturates at FF.
    exp_cnt = 8'd0;
    for (int n = 0; n < 260; n++) begin
      apply_stimulus(8'hA5);
      apply_stimulus(8'h02);
      apply_stimulus(8'h00);
      apply_stimulus(8'h10);
      apply_stimulus(8'h00);
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      check_output($sformatf("sat.n%0d", n), 32'(bus.err_count), 32'(exp_cnt));
    end
    @(negedge clk);
    check_status("sat.final", 1'b0, 1'b0, 8'h01, 16'h1234, 8'hFF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
